// File: rtl/inst_mem_loadable.sv
// Loadable instruction memory: a valid/ready stream writes words from address 0,
// the unwritten tail is filled with FILL, then fetch reads are served.
// Ports: clk_i/reset_i; load stream in (start/valid/last/data) with load_ready_o;
//        fetch in (inst_address_i, fetch_en_i); inst_out_o/inst_valid_o, loaded_o, load_count_o.
// Latency: fetch 1 cycle (REG_OUT=1) or 0 (REG_OUT=0); load accepts one word per cycle in LOAD.
module inst_mem_loadable #(
    parameter int            IW      = 9,
    parameter int            DW      = 9,
    parameter int            REG_OUT = 1,
    parameter logic [DW-1:0] FILL    = '0
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          load_start_i,
    input  logic          load_valid_i,
    input  logic          load_last_i,
    input  logic [DW-1:0] load_data_i,
    output logic          load_ready_o,
    input  logic [IW-1:0] inst_address_i,
    input  logic          fetch_en_i,
    output logic [DW-1:0] inst_out_o,
    output logic          inst_valid_o,
    output logic          loaded_o,
    output logic [IW:0]   load_count_o
);

    localparam logic [IW-1:0] PTR_MAX = {IW{1'b1}};
    localparam logic [IW:0]   CNT_MAX = {1'b1, {IW{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_RUN} state_t;

    state_t        state_q;
    logic [IW-1:0] ptr_q;
    logic [IW:0]   cnt_q;
    logic          ready_q;
    logic          loaded_q;

    logic [DW-1:0] mem [2**IW];

    logic          accept_d;
    logic          wr_en_d;
    logic [DW-1:0] wr_dat_d;

    assign accept_d = (state_q == S_LOAD) && ready_q && load_valid_i;
    // Reset wins over a write in flight, so a reset edge never touches the array.
    assign wr_en_d  = !reset_i && (accept_d || (state_q == S_FILL));
    assign wr_dat_d = (state_q == S_FILL) ? FILL : load_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (load_start_i) begin
                        state_q <= S_LOAD;
                        ptr_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept_d) begin
                        ptr_q <= ptr_q + 1'b1;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        // Last address written: nothing left to fill.
                        if (ptr_q == PTR_MAX) begin
                            state_q  <= S_RUN;
                            ready_q  <= 1'b0;
                            loaded_q <= 1'b1;
                        end else if (load_last_i) begin
                            state_q <= S_FILL;
                            ready_q <= 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == PTR_MAX) begin
                        state_q  <= S_RUN;
                        loaded_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (load_start_i) begin
                        state_q  <= S_LOAD;
                        ptr_q    <= '0;
                        cnt_q    <= '0;
                        ready_q  <= 1'b1;
                        loaded_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Array has no reset: contents survive reset and reload.
    always_ff @(posedge clk_i) begin
        if (wr_en_d) begin
            mem[ptr_q] <= wr_dat_d;
        end
    end

    generate
        if (REG_OUT != 0) begin : g_reg
            logic          fetch_go;
            logic [DW-1:0] out_q;
            logic          vld_q;

            // A reload request in the same cycle cancels the fetch.
            assign fetch_go = loaded_q && fetch_en_i && !load_start_i;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    out_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= fetch_go;
                    if (fetch_go) begin
                        out_q <= mem[inst_address_i];
                    end
                end
            end

            assign inst_out_o   = out_q;
            assign inst_valid_o = vld_q;
        end else begin : g_comb
            assign inst_out_o   = mem[inst_address_i];
            assign inst_valid_o = fetch_en_i && loaded_q;
        end
    endgenerate

    assign load_ready_o = ready_q;
    assign loaded_o     = loaded_q;
    assign load_count_o = cnt_q;

endmodule

// File: tb/tb_inst_mem_loadable.sv
module tb_inst_mem_loadable;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start, load_valid, load_last;
    logic [8:0] load_data;
    logic       fetch_en1, fetch_en0;
    logic [3:0] addr1, addr0;

    logic       ready1, vld1, loaded1;
    logic [8:0] out1;
    logic [4:0] cnt1;
    logic       ready0, vld0, loaded0;
    logic [8:0] out0;
    logic [4:0] cnt0;

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] q1[$];
    logic [8:0] q0[$];

    always #5 clk = ~clk;

    inst_mem_loadable #(.IW(4), .DW(9), .REG_OUT(1), .FILL(9'h000)) dut1 (
        .clk_i(clk), .reset_i(reset),
        .load_start_i(load_start), .load_valid_i(load_valid), .load_last_i(load_last),
        .load_data_i(load_data), .load_ready_o(ready1),
        .inst_address_i(addr1), .fetch_en_i(fetch_en1),
        .inst_out_o(out1), .inst_valid_o(vld1), .loaded_o(loaded1), .load_count_o(cnt1)
    );

    inst_mem_loadable #(.IW(4), .DW(9), .REG_OUT(0), .FILL(9'h000)) dut0 (
        .clk_i(clk), .reset_i(reset),
        .load_start_i(load_start), .load_valid_i(load_valid), .load_last_i(load_last),
        .load_data_i(load_data), .load_ready_o(ready0),
        .inst_address_i(addr0), .fetch_en_i(fetch_en0),
        .inst_out_o(out0), .inst_valid_o(vld0), .loaded_o(loaded0), .load_count_o(cnt0)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every valid fetch result must match the oldest expectation.
    always @(negedge clk) begin
        if (vld1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_err++;
                $display("FAIL fetch1_unexpected: got valid data 0x%0h, expected no valid", out1);
            end else begin
                logic [8:0] e;
                e = q1.pop_front();
                if (out1 !== e) begin
                    n_err++;
                    $display("FAIL fetch1_data: got 0x%0h, expected 0x%0h", out1, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (vld0) begin
            n_vec++;
            if (q0.size() == 0) begin
                n_err++;
                $display("FAIL fetch0_unexpected: got valid data 0x%0h, expected no valid", out0);
            end else begin
                logic [8:0] e;
                e = q0.pop_front();
                if (out0 !== e) begin
                    n_err++;
                    $display("FAIL fetch0_data: got 0x%0h, expected 0x%0h", out0, e);
                end
            end
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        cyc(1);
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [8:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ready1) ok = 1'b1;
        end
        if (!ok) begin
            n_err++;
            $display("FAIL load_ready_timeout: got ready=0, expected ready=1");
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Returns how many cycles passed until Loaded, checking LoadReady stays low.
    task automatic wait_loaded(output int n);
        n = 0;
        while (!loaded1 && n < 100) begin
            if (ready1) begin
                n_err++;
                $display("FAIL fill_ready: got ready=1, expected ready=0");
            end
            cyc(1);
            n++;
        end
    endtask

    task automatic fetch1(input logic [3:0] a, input logic [8:0] e);
        fetch_en1 = 1'b1;
        addr1     = a;
        q1.push_back(e);
        cyc(1);
        fetch_en1 = 1'b0;
    endtask

    task automatic fetch0(input logic [3:0] a, input logic [8:0] e);
        fetch_en0 = 1'b1;
        addr0     = a;
        q0.push_back(e);
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        load_data = '0; fetch_en1 = 1'b0; fetch_en0 = 1'b0; addr1 = '0; addr0 = '0;
        cyc(2);
        reset = 1'b0;
        check("rst_ready", int'(ready1), 0);
        check("rst_loaded", int'(loaded1), 0);
        check("rst_count", int'(cnt1), 0);
        check("rst_valid", int'(vld1), 0);
        check("rst_out", int'(out1), 0);

        // Short program, tail filled.
        start_load();
        check("load_ready_up", int'(ready1), 1);
        send_word(9'h101, 1'b0);
        send_word(9'h102, 1'b0);
        send_word(9'h103, 1'b1);
        wait_loaded(n);
        check("fill_cycles", n, 13);
        check("count3", int'(cnt1), 3);
        fetch1(4'd2, 9'h103);
        cyc(1);
        check("valid_drop", int'(vld1), 0);
        check("out_hold", int'(out1), 'h103);
        fetch1(4'd9, 9'h000);
        fetch1(4'd0, 9'h101);

        // Full program, no fill.
        start_load();
        for (int i = 0; i < 16; i++) send_word(9'h1F0 | 9'(i), 1'b0);
        check("full_loaded_now", int'(loaded1), 1);
        check("count16", int'(cnt1), 16);
        fetch1(4'd15, 9'h1FF);
        fetch1(4'd4, 9'h1F4);

        // Combinational-read build, same contents.
        check("comb_loaded", int'(loaded0), 1);
        fetch0(4'd3, 9'h1F3);
        fetch0(4'd10, 9'h1FA);
        fetch0(4'd15, 9'h1FF);
        fetch_en0 = 1'b0;
        #1;
        check("comb_valid_off", int'(vld0), 0);

        // Gaps in the stream.
        start_load();
        send_word(9'h0AA, 1'b0);
        check("gap_count1", int'(cnt1), 1);
        load_data = 9'h0BB;
        cyc(2);
        check("gap_count_idle", int'(cnt1), 1);
        send_word(9'h0DD, 1'b1);
        check("gap_count2", int'(cnt1), 2);
        wait_loaded(n);
        check("gap_fill_cycles", n, 14);
        fetch1(4'd0, 9'h0AA);
        fetch1(4'd1, 9'h0DD);
        fetch1(4'd2, 9'h000);

        // Reload while fetching: load wins.
        load_start = 1'b1;
        fetch_en1  = 1'b1;
        addr1      = 4'd0;
        cyc(1);
        load_start = 1'b0;
        fetch_en1  = 1'b0;
        check("reload_valid", int'(vld1), 0);
        check("reload_loaded", int'(loaded1), 0);
        check("reload_count", int'(cnt1), 0);
        send_word(9'h055, 1'b0);
        send_word(9'h066, 1'b1);
        wait_loaded(n);
        fetch1(4'd1, 9'h066);
        fetch1(4'd5, 9'h000);

        // Reset in the middle of the fill.
        start_load();
        send_word(9'h011, 1'b0);
        send_word(9'h012, 1'b0);
        send_word(9'h013, 1'b1);
        cyc(4);
        check("mid_fill_loaded", int'(loaded1), 0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("rst2_loaded", int'(loaded1), 0);
        check("rst2_count", int'(cnt1), 0);
        check("rst2_ready", int'(ready1), 0);
        fetch_en1 = 1'b1;
        addr1     = 4'd0;
        cyc(1);
        fetch_en1 = 1'b0;
        check("idle_fetch_valid", int'(vld1), 0);
        start_load();
        send_word(9'h021, 1'b1);
        wait_loaded(n);
        check("after_rst_fill", n, 15);
        check("after_rst_count", int'(cnt1), 1);
        fetch1(4'd0, 9'h021);
        fetch1(4'd7, 9'h000);

        cyc(2);
        check("q1_drained", q1.size(), 0);
        check("q0_drained", q0.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/inst_mem_loadable.md
Name: inst_mem_loadable

Overview:
- Parametrised successor to the fixed instruction ROM.
- Instruction memory is written at run time through a valid/ready load stream instead of a file, with unwritten tail words filled automatically.
- Serves fetch with a registered, one-cycle-latency read (or a combinational read when REG_OUT=0) plus a valid flag.
- Sits between the program loader/testbench and the fetch stage of the core.

Parameters:
IW, 9, address width; depth = 2**IW words
DW, 9, instruction word width
REG_OUT, 1, 1 = registered read (latency 1); 0 = combinational read (latency 0)
FILL, 0 (DW bits), word written to every address not covered by the load stream

Ports:
Clk  input  1  single clock, all state on rising edge
Reset  input  1  synchronous, active-high
LoadStart  input  1  pulse: begin a new program load
LoadValid  input  1  LoadData holds a valid word
LoadLast  input  1  qualifies the current LoadValid word as the final word
LoadData  input  DW  word to write at the next sequential address
LoadReady  output  1  block accepts a word this cycle
InstAddress  input  IW  fetch address
FetchEn  input  1  fetch request
InstOut  output  DW  fetched instruction
InstValid  output  1  InstOut holds a valid fetch result
Loaded  output  1  memory holds a complete program; fetch enabled
LoadCount  output  IW+1  number of words accepted in the current/last load

Behaviour:
- Reset values: FSM=IDLE, LoadReady=0, InstOut=0, InstValid=0, Loaded=0, LoadCount=0. Memory array is not cleared by Reset; its contents are retained.
- FSM states:
  - IDLE:
    - LoadStart -> LOAD, with ptr=0 and LoadCount=0.
  - LOAD:
    - LoadReady=1.
    - A word is accepted on LoadValid&&LoadReady: mem[ptr]<=LoadData, ptr++, LoadCount++.
    - On acceptance with LoadLast=1, or on acceptance of word 2**IW-1 (ptr wrap): go to FILL if ptr+1<2**IW, else RUN.
    - LoadStart is ignored in this state.
  - FILL:
    - LoadReady=0.
    - Writes FILL to mem[ptr] and increments ptr each cycle.
    - After the write to address 2**IW-1 -> RUN.
    - LoadCount does not change.
  - RUN:
    - Loaded=1; fetch is active.
    - LoadStart -> LOAD: Loaded drops to 0 the next cycle, ptr=0, LoadCount=0, InstValid=0.
- Loaded=1 only in RUN.
- LoadCount saturates at 2**IW; it is never reset by the transition to RUN.
- Fetch, REG_OUT=1:
  - In RUN with FetchEn=1 at edge t: InstOut=mem[InstAddress] and InstValid=1 after edge t.
  - FetchEn=0: InstValid=0 next cycle, InstOut holds its value.
- Fetch, REG_OUT=0:
  - InstOut=mem[InstAddress] combinationally.
  - InstValid = FetchEn && Loaded.
- Outside RUN: InstValid=0 in both modes; fetch has no side effects.
- Simultaneous events:
  - Reset dominates everything.
  - In RUN, LoadStart and FetchEn in the same cycle: the load wins and InstValid=0.
  - A write and a read never coexist, because fetch is active only in RUN.
- Reset mid-LOAD or mid-FILL: FSM returns to IDLE and Loaded=0. Partial contents remain but are unusable until a new load completes.
- Zero-word load is not supported; the first accepted word always writes address 0.

Test Plan:
- IW=4, DW=9. Reset, LoadStart, stream 0x101,0x102,0x103 with LoadLast on the third word.
  - LoadReady low for 13 cycles (FILL writes addresses 3..15), then Loaded=1 and LoadCount=3.
  - Fetch addr 2 -> InstOut=0x103, InstValid=1 one cycle later (REG_OUT=1).
  - Fetch addr 9 -> 0x000.
- Full load of 16 words (value = 0x1F0|i) without LoadLast.
  - Goes directly to RUN after word 15, with no FILL cycles.
  - LoadCount=16; fetch addr 15 -> 0x1FF.
- Backpressure/gaps: LoadValid toggles 1,0,0,1.
  - Only the 2 valid cycles write, at addresses 0 and 1.
  - LoadCount=2 after both; no writes occur on idle cycles.
- Reload from RUN: assert LoadStart and FetchEn in the same cycle.
  - InstValid=0 and Loaded=0 the next cycle.
  - A new program of 2 words gives fetch addr 1 = new value and addr 5 = FILL.
- Reset during FILL (at ptr=7), then LoadStart.
  - IDLE, Loaded=0, LoadCount=0 after reset.
  - FetchEn in IDLE gives InstValid=0.
  - The subsequent load completes normally.
- REG_OUT=0 build.
  - InstOut tracks InstAddress in the same cycle after the load.
  - InstValid = FetchEn while Loaded=1.
